dffram_sync: RTL and testbench
==============================

# dffram_sync

Parametrised single-port flip-flop RAM with registered read data, per-byte write enables, a req/rdy handshake and a hardware clear sweep. It is the general-purpose successor to the fixed 8x16 DFF memory. It sits directly behind a bus-side requester that holds a request until `rdy` accepts it. Storage is plain flops, so it is sized for small register files and scratch buffers (DEPTH ≤ 64).

## Interface
- WIDTH, default 16: data width in bits; must be a multiple of 8.
- DEPTH, default 8: number of words, 2..64; need not be a power of two.
- AW, default $clog2(DEPTH): address width (derived, not overridden).
- clkp  in  1  clock; all state changes on the rising edge.
- rstp  in  1  reset, asynchronous, active-high.
- req  in  1  access request; accepted only on a cycle where req && rdy.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  AW  word address; sampled with req.
- be  in  WIDTH/8  byte-lane write enables; bit i covers din[8i+7:8i]; ignored on reads.
- din  in  WIDTH  write data.
- clr  in  1  one-cycle pulse that starts a zeroing sweep of the whole array.
- rdy  out  1  combinational: (state == IDLE) && !clr.
- dout  out  WIDTH  registered read data; holds its value until the next accepted read.
- dvalid  out  1  one-cycle pulse marking new dout.
- busy  out  1  high while a clear sweep is in progress.
- err  out  1  one-cycle pulse for an accepted access with addr ≥ DEPTH.

## Operation
- Reset (rstp=1, asynchronous) sets every array word, dout and the sweep counter to 0, and sets dvalid, busy and err to 0. State goes to IDLE.
- The block has two states: IDLE and CLEAR.
- IDLE, accepted write: at the edge, each word byte with be[i]=1 takes the corresponding din byte; other bytes are unchanged. be=0 is a legal no-op write. dout and dvalid are unaffected.
- IDLE, accepted read: at the edge, dout takes mem[addr] and dvalid=1 for exactly one cycle.
- Out of range (addr ≥ DEPTH):
  - write: no array change; err=1 for one cycle.
  - read: dout=0, dvalid=1 and err=1, each for one cycle.
- clr=1 in IDLE forces rdy=0, so any req that cycle is not accepted; clr wins. The next state is CLEAR with counter=0.
- CLEAR: each cycle writes 0 to mem[counter] and increments counter. After writing word DEPTH-1, the next state is IDLE. busy=1 and rdy=0 throughout, and req is ignored; the requester must hold req.
- clr=1 while in CLEAR restarts the sweep at counter=0.
- The port is single-ported, so at most one access is accepted per cycle. A read issued the cycle after a write to the same address returns the new data.

## Timing
- rdy is a combinational function of state and clr; there is no registered path from req to rdy.
- Write: data is visible in the array at the accepting edge. Read latency is 1 cycle: dout and dvalid are valid in the cycle after acceptance.
- Back-to-back accepted reads produce dvalid on consecutive cycles.
- Clear: with clr sampled at edge N, busy=1 from edge N through edge N+DEPTH, and rdy=1 again after edge N+DEPTH. Total duration is DEPTH cycles.
- rstp asserted mid-sweep aborts the sweep immediately. The array is zeroed by the reset itself, and busy=0 asynchronously.
- dout is not cleared by clr; it keeps the last read value.

## Test plan
- Reset then read: assert rstp, release it, read addr 0..7 -> dout=0x0000 with dvalid pulsed on each read; err=0; busy=0.
- Byte-lane write: write 0xA5A5 with be=11 to addr 3, then write 0x1234 with be=01 to addr 3, then read addr 3 -> dout=0xA534 one cycle after acceptance.
- Handshake under clear: fill all 8 words with 0xFFFF, pulse clr while holding a read req to addr 5 -> rdy=0 and busy=1 for 8 cycles. The read is then accepted and returns 0x0000.
- Simultaneous clr and req in IDLE: write req to addr 2 with data 0x5555, coincident with clr -> the write is not accepted. After the sweep, the held write completes and a read of addr 2 returns 0x5555.
- Out of range: DEPTH=6, WIDTH=32. A write to addr 7 pulses err and leaves the array unchanged. A read of addr 6 returns dout=0 with dvalid=1 and err=1.
- Reset mid-sweep: pulse clr, then assert rstp at sweep cycle 3 -> busy drops immediately and all words read 0 after release. The next clr completes in exactly DEPTH cycles.

Source files
------------

// File: rtl/dffram_sync.sv
// dffram_sync: single-port flip-flop RAM (WIDTH x DEPTH) with registered
// read data, per-byte write enables, a req/rdy handshake and a hardware
// clear sweep that zeroes the whole array, one word per cycle.
//
// Parameters:
//   WIDTH  data width in bits (multiple of 8)
//   DEPTH  number of words, 2..64 (any value, not only powers of two)
//   AW     address width, derived from DEPTH
// Ports:
//   clkp    clock, rising edge
//   rstp    asynchronous active-high reset; zeroes array and outputs
//   req     access request, accepted when req && rdy
//   we      1 = write, 0 = read (sampled with req)
//   addr    word address (sampled with req)
//   be      byte-lane write enables, bit i covers din[8i+7:8i]
//   din     write data
//   clr     one-cycle pulse that starts (or restarts) a zeroing sweep
//   rdy     combinational: idle and no clr this cycle
//   dout    registered read data, held until the next accepted read
//   dvalid  one-cycle pulse marking new dout
//   busy    high while a clear sweep is running
//   err     one-cycle pulse for an accepted access with addr >= DEPTH
module dffram_sync #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clkp,
  input  logic               rstp,
  input  logic               req,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   din,
  input  logic               clr,
  output logic               rdy,
  output logic [WIDTH-1:0]   dout,
  output logic               dvalid,
  output logic               busy,
  output logic               err
);

  localparam int unsigned NB      = WIDTH / 8;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_dout;
  logic              r_dvalid;
  logic              r_busy;
  logic              r_err;

  logic              w_idle_acc;
  logic              w_in_range;
  logic [WIDTH-1:0]  w_wdata [DEPTH];
  logic [DEPTH-1:0]  w_wsel;
  logic [DEPTH-1:0]  w_zero;

  assign rdy        = (r_state == S_IDLE) && !clr;
  assign w_idle_acc = req && rdy;
  // Extra MSB so DEPTH itself (e.g. 64 with AW=6) is representable.
  assign w_in_range = ({1'b0, addr} < LP_DEPTH);

  assign dout   = r_dout;
  assign dvalid = r_dvalid;
  assign busy   = r_busy;
  assign err    = r_err;

  // Each word is its own flop group: selected by an in-range write, or
  // zeroed when the sweep counter reaches it. A clr during the sweep
  // restarts the counter instead of writing that cycle.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    assign w_wsel[g] = w_idle_acc && we && (addr == AW'(g));
    assign w_zero[g] = (r_state == S_CLEAR) && !clr && (r_cnt == AW'(g));

    always_comb begin
      w_wdata[g] = r_mem[g];
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) w_wdata[g][8*i +: 8] = din[8*i +: 8];
      end
    end

    always_ff @(posedge clkp or posedge rstp) begin
      if (rstp)           r_mem[g] <= '0;
      else if (w_zero[g]) r_mem[g] <= '0;
      else if (w_wsel[g]) r_mem[g] <= w_wdata[g];
    end
  end

  always_ff @(posedge clkp or posedge rstp) begin
    if (rstp) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clr) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (req) begin
            if (we) begin
              if (!w_in_range) r_err <= 1'b1;
            end else begin
              r_dvalid <= 1'b1;
              if (w_in_range) begin
                r_dout <= r_mem[addr];
              end else begin
                r_dout <= '0;
                r_err  <= 1'b1;
              end
            end
          end
        end
        S_CLEAR: begin
          if (clr) begin
            r_cnt <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dffram_sync.sv
// tb_dffram_sync: directed self-checking bench for dffram_sync.
// Instance A uses the defaults (16 x 8); instance B is 32 x 6 for the
// out-of-range and non-power-of-two depth cases.
module tb_dffram_sync;

  logic clkp = 1'b0;
  logic rstp;
  always #5 clkp = ~clkp;

  // Instance A: WIDTH=16, DEPTH=8
  logic        a_req, a_we, a_clr;
  logic [2:0]  a_addr;
  logic [1:0]  a_be;
  logic [15:0] a_din;
  logic        a_rdy, a_dvalid, a_busy, a_err;
  logic [15:0] a_dout;

  // Instance B: WIDTH=32, DEPTH=6
  logic        b_req, b_we, b_clr;
  logic [2:0]  b_addr;
  logic [3:0]  b_be;
  logic [31:0] b_din;
  logic        b_rdy, b_dvalid, b_busy, b_err;
  logic [31:0] b_dout;

  dffram_sync u_dut_a (
    .clkp(clkp), .rstp(rstp), .req(a_req), .we(a_we), .addr(a_addr),
    .be(a_be), .din(a_din), .clr(a_clr), .rdy(a_rdy), .dout(a_dout),
    .dvalid(a_dvalid), .busy(a_busy), .err(a_err)
  );

  dffram_sync #(.WIDTH(32), .DEPTH(6)) u_dut_b (
    .clkp(clkp), .rstp(rstp), .req(b_req), .we(b_we), .addr(b_addr),
    .be(b_be), .din(b_din), .clr(b_clr), .rdy(b_rdy), .dout(b_dout),
    .dvalid(b_dvalid), .busy(b_busy), .err(b_err)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkp);
    #1;
  endtask

  task automatic acc_a(input logic w, input logic [2:0] ad, input logic [1:0] b,
                       input logic [15:0] d);
    a_req = 1'b1; a_we = w; a_addr = ad; a_be = b; a_din = d;
    tick();
    a_req = 1'b0;
  endtask

  task automatic acc_b(input logic w, input logic [2:0] ad, input logic [3:0] b,
                       input logic [31:0] d);
    b_req = 1'b1; b_we = w; b_addr = ad; b_be = b; b_din = d;
    tick();
    b_req = 1'b0;
  endtask

  // Counts cycles with busy high, bounded so a stuck sweep cannot hang.
  task automatic count_busy_a(output int n);
    n = 0;
    while (a_busy === 1'b1 && n < 40) begin
      chk("a_sweep_rdy_low", {31'b0, a_rdy}, 32'd0);
      n++;
      tick();
    end
  endtask

  task automatic count_busy_b(output int n);
    n = 0;
    while (b_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstp = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_clr = 1'b0; a_addr = '0; a_be = '0; a_din = '0;
    b_req = 1'b0; b_we = 1'b0; b_clr = 1'b0; b_addr = '0; b_be = '0; b_din = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_dout",   {16'b0, a_dout}, 32'd0);
    chk("rst_dvalid", {31'b0, a_dvalid}, 32'd0);
    chk("rst_busy",   {31'b0, a_busy}, 32'd0);
    chk("rst_err",    {31'b0, a_err}, 32'd0);
    chk("rst_rdy",    {31'b0, a_rdy}, 32'd1);
    chk("rst_b_dout", b_dout, 32'd0);
    rstp = 1'b0;
    tick();

    // Reset then read every word
    for (int i = 0; i < 8; i++) begin
      acc_a(1'b0, 3'(i), 2'b00, 16'h0000);
      chk("rd0_dout",   {16'b0, a_dout}, 32'd0);
      chk("rd0_dvalid", {31'b0, a_dvalid}, 32'd1);
      chk("rd0_err",    {31'b0, a_err}, 32'd0);
      chk("rd0_busy",   {31'b0, a_busy}, 32'd0);
    end
    tick();
    chk("dvalid_one_cycle", {31'b0, a_dvalid}, 32'd0);

    // Byte lanes, including an all-lanes-off write
    acc_a(1'b1, 3'd3, 2'b11, 16'hA5A5);
    chk("wr_no_dvalid", {31'b0, a_dvalid}, 32'd0);
    acc_a(1'b1, 3'd3, 2'b01, 16'h1234);
    acc_a(1'b0, 3'd3, 2'b00, 16'h0000);
    chk("be_lo_merge", {16'b0, a_dout}, 32'h0000_A534);
    acc_a(1'b1, 3'd3, 2'b00, 16'hFFFF);
    acc_a(1'b0, 3'd3, 2'b00, 16'h0000);
    chk("be_none_noop", {16'b0, a_dout}, 32'h0000_A534);
    acc_a(1'b1, 3'd3, 2'b10, 16'h7E00);
    acc_a(1'b0, 3'd3, 2'b00, 16'h0000);
    chk("be_hi_merge", {16'b0, a_dout}, 32'h0000_7E34);

    // Handshake under clear: read req to addr 5 held across the sweep
    for (int i = 0; i < 8; i++) acc_a(1'b1, 3'(i), 2'b11, 16'hFFFF);
    acc_a(1'b0, 3'd5, 2'b00, 16'h0000);
    chk("fill_rd5", {16'b0, a_dout}, 32'h0000_FFFF);
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd5; a_clr = 1'b1;
    #1;
    chk("clr_blocks_rdy", {31'b0, a_rdy}, 32'd0);
    tick();
    a_clr = 1'b0;
    count_busy_a(n_busy);
    chk("clr_busy_cycles", n_busy, 32'd8);
    chk("clr_no_early_rd", {31'b0, a_dvalid}, 32'd0);
    chk("clr_rdy_back",    {31'b0, a_rdy}, 32'd1);
    tick();
    a_req = 1'b0;
    chk("held_rd_dout",   {16'b0, a_dout}, 32'd0);
    chk("held_rd_dvalid", {31'b0, a_dvalid}, 32'd1);
    acc_a(1'b0, 3'd0, 2'b00, 16'h0000);
    chk("clr_word0", {16'b0, a_dout}, 32'd0);
    acc_a(1'b0, 3'd7, 2'b00, 16'h0000);
    chk("clr_word7", {16'b0, a_dout}, 32'd0);

    // clr coincident with a write request: clr wins, write completes later
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd2; a_be = 2'b11; a_din = 16'h5555;
    a_clr = 1'b1;
    #1;
    chk("clr_wr_rdy", {31'b0, a_rdy}, 32'd0);
    tick();
    a_clr = 1'b0;
    count_busy_a(n_busy);
    chk("clr_wr_busy_cycles", n_busy, 32'd8);
    tick();
    a_req = 1'b0;
    acc_a(1'b0, 3'd2, 2'b00, 16'h0000);
    chk("held_wr_data", {16'b0, a_dout}, 32'h0000_5555);

    // Read right after write to the same address, then back-to-back reads
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd4; a_be = 2'b11; a_din = 16'hBEEF;
    tick();
    a_we = 1'b0;
    tick();
    chk("raw_dout",   {16'b0, a_dout}, 32'h0000_BEEF);
    chk("raw_dvalid", {31'b0, a_dvalid}, 32'd1);
    a_addr = 3'd2;
    tick();
    a_req = 1'b0;
    chk("b2b_dout",   {16'b0, a_dout}, 32'h0000_5555);
    chk("b2b_dvalid", {31'b0, a_dvalid}, 32'd1);
    tick();
    chk("hold_dvalid", {31'b0, a_dvalid}, 32'd0);
    chk("hold_dout",   {16'b0, a_dout}, 32'h0000_5555);

    // Reset in the middle of a sweep
    acc_a(1'b1, 3'd7, 2'b11, 16'h7777);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    tick();
    tick();
    chk("mid_busy_before", {31'b0, a_busy}, 32'd1);
    rstp = 1'b1;
    #1;
    chk("mid_rst_busy_async", {31'b0, a_busy}, 32'd0);
    chk("mid_rst_dout",       {16'b0, a_dout}, 32'd0);
    tick();
    rstp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      acc_a(1'b0, 3'(i), 2'b00, 16'h0000);
      chk("post_rst_word", {16'b0, a_dout}, 32'd0);
    end
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    count_busy_a(n_busy);
    chk("post_rst_sweep_len", n_busy, 32'd8);

    // Instance B: out-of-range handling and 6-word sweep
    acc_b(1'b1, 3'd0, 4'hF, 32'hDEAD_BEEF);
    chk("b_wr_err0", {31'b0, b_err}, 32'd0);
    acc_b(1'b1, 3'd5, 4'hF, 32'h0102_0304);
    acc_b(1'b1, 3'd7, 4'hF, 32'hFFFF_FFFF);
    chk("b_oor_wr_err",    {31'b0, b_err}, 32'd1);
    chk("b_oor_wr_dvalid", {31'b0, b_dvalid}, 32'd0);
    tick();
    chk("b_err_one_cycle", {31'b0, b_err}, 32'd0);
    acc_b(1'b0, 3'd0, 4'h0, 32'h0);
    chk("b_rd0",     b_dout, 32'hDEAD_BEEF);
    chk("b_rd0_err", {31'b0, b_err}, 32'd0);
    acc_b(1'b0, 3'd5, 4'h0, 32'h0);
    chk("b_rd5_last", b_dout, 32'h0102_0304);
    acc_b(1'b0, 3'd6, 4'h0, 32'h0);
    chk("b_oor_rd_dout",   b_dout, 32'd0);
    chk("b_oor_rd_dvalid", {31'b0, b_dvalid}, 32'd1);
    chk("b_oor_rd_err",    {31'b0, b_err}, 32'd1);
    tick();
    chk("b_oor_err_clear",    {31'b0, b_err}, 32'd0);
    chk("b_oor_dvalid_clear", {31'b0, b_dvalid}, 32'd0);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    count_busy_b(n_busy);
    chk("b_sweep_len", n_busy, 32'd6);
    acc_b(1'b0, 3'd5, 4'h0, 32'h0);
    chk("b_cleared5", b_dout, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
